// File: rtl/prbs_pkg.sv
// Shared types and defaults for the PRBS31 receive-side checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_t;

    localparam int PRBS31_BITS  = 31;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

    // XNOR feedback, so the all-zero register is a legal seed.
    function automatic logic prbs_predict(input logic tap_a, input logic tap_b);
        return tap_a ~^ tap_b;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Serial bit stream in, lock/error status out, for the PRBS checker.
interface prbs_checker_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_bit;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output in_valid, in_bit, clear_counts,
        input  locked, err_pulse, err_count, bit_count
    );

    modport slave (
        input  in_valid, in_bit, clear_counts,
        output locked, err_pulse, err_count, bit_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] cnt_q;

    // Count register with clear priority and saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS31 (XNOR) checker: load, confirm, then free-run and
// count mispredicted bits.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int NUM_BITS   = PRBS31_BITS,
    parameter int TAP_A      = PRBS31_TAP_A,
    parameter int TAP_B      = PRBS31_TAP_B,
    parameter int LOCK_COUNT = 64,
    parameter int LOSS_COUNT = 8,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    prbs_checker_if.slave  bus
);
    localparam int LOAD_W  = $clog2(NUM_BITS + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(NUM_BITS - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_COUNT - 1);

    prbs_state_t        state_q;
    logic [NUM_BITS:1]  sr_q;
    logic [LOAD_W-1:0]  load_cnt_q;
    logic [MATCH_W-1:0] match_cnt_q;
    logic [LOSS_W-1:0]  consec_q;
    logic               locked_q;
    logic               err_pulse_q;

    logic               exp_s;
    logic               mismatch_s;
    logic [NUM_BITS:1]  shift_in_s;
    logic [NUM_BITS:1]  shift_exp_s;
    logic               bit_inc_s;
    logic               err_inc_s;
    logic [CNT_W-1:0]   err_count_s;
    logic [CNT_W-1:0]   bit_count_s;

    assign exp_s       = prbs_predict(sr_q[TAP_A], sr_q[TAP_B]);
    assign mismatch_s  = (bus.in_bit != exp_s);
    assign shift_in_s  = {sr_q[NUM_BITS-1:1], bus.in_bit};
    assign shift_exp_s = {sr_q[NUM_BITS-1:1], exp_s};
    assign bit_inc_s   = bus.in_valid && (state_q == ST_LOCKED);
    assign err_inc_s   = bit_inc_s && mismatch_s;

    // Acquisition/tracking FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            sr_q        <= '0;
            load_cnt_q  <= '0;
            match_cnt_q <= '0;
            consec_q    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    ST_LOAD: begin
                        sr_q <= shift_in_s;
                        // All ones is the XNOR lock-up state: never accept it as a seed.
                        if (&shift_in_s) begin
                            load_cnt_q <= '0;
                        end else if (load_cnt_q == LOAD_LAST) begin
                            load_cnt_q  <= '0;
                            match_cnt_q <= '0;
                            state_q     <= ST_SYNC;
                        end else begin
                            load_cnt_q <= load_cnt_q + LOAD_W'(1);
                        end
                    end
                    ST_SYNC: begin
                        sr_q <= shift_in_s;
                        if (!mismatch_s) begin
                            if (match_cnt_q == MATCH_LAST) begin
                                consec_q <= '0;
                                locked_q <= 1'b1;
                                state_q  <= ST_LOCKED;
                            end else begin
                                match_cnt_q <= match_cnt_q + MATCH_W'(1);
                            end
                        end else begin
                            load_cnt_q <= '0;
                            state_q    <= ST_LOAD;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on our own prediction so a line error is counted once.
                        sr_q <= shift_exp_s;
                        if (mismatch_s) begin
                            err_pulse_q <= 1'b1;
                            if (consec_q == LOSS_LAST) begin
                                sr_q       <= '0;
                                load_cnt_q <= '0;
                                locked_q   <= 1'b0;
                                state_q    <= ST_LOAD;
                            end else begin
                                consec_q <= consec_q + LOSS_W'(1);
                            end
                        end else begin
                            consec_q <= '0;
                        end
                    end
                    default: begin
                        sr_q       <= '0;
                        load_cnt_q <= '0;
                        locked_q   <= 1'b0;
                        state_q    <= ST_LOAD;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear_counts),
        .inc   (err_inc_s),
        .q     (err_count_s)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear_counts),
        .inc   (bit_inc_s),
        .q     (bit_count_s)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_s;
    assign bus.bit_count = bit_count_s;

endmodule
